atm_login_ctrl: RTL and testbench
=================================

Name: atm_login_ctrl

Overview:
- Sequential session controller directly upstream of the Authenticator.
- Captures a card's account number, then accumulates keypad PIN digits into a decimal binary value and drives the Authenticator's acc_num/pin inputs.
- Samples the Authenticator's found/auth results and enforces retry limits, per-account lockout and entry timeout.
- On success, hands the authenticated account index to the downstream transaction logic.

Parameters:
- MAX_ATTEMPTS, 3, wrong-PIN tries per session before the account is locked
- TIMEOUT_CYCLES, 1000, idle cycles allowed between keypad digits
- NUM_ACCOUNTS, 10, size of the lock bitmap (indices 0..NUM_ACCOUNTS-1)
- PIN_DIGITS, 4, digits per PIN

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- card_in  in  1  one-cycle pulse: card inserted, acc_num_in valid
- acc_num_in  in  4  account number from card
- digit_valid  in  1  one-cycle keypad strobe
- digit  in  4  BCD keypad digit
- cancel  in  1  abort / logout request
- auth_found  in  1  Authenticator acc_found_stat
- auth_ok  in  1  Authenticator acc_auth_stat
- auth_index  in  4  Authenticator acc_index_out
- acc_num  out  4  registered account number to Authenticator
- pin  out  16  registered decimal PIN value to Authenticator
- session_active  out  1  high while in GRANTED
- session_index  out  4  authenticated account index, valid when session_active
- attempts_left  out  2  remaining tries this session
- status  out  3  result code
- status_valid  out  1  one-cycle pulse qualifying status

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE, acc_num=0, pin=0, session_active=0, session_index=0, attempts_left=MAX_ATTEMPTS, status=0, status_valid=0, lock bitmap all 0, timeout counter 0.
- Status codes: 0 NONE, 1 GRANTED, 2 BAD_PIN, 3 NOT_FOUND, 4 LOCKED, 5 TIMEOUT, 6 CANCELLED.
- status_valid pulses exactly one cycle per event; status holds its value until the next event.
- IDLE: on card_in, latch acc_num<=acc_num_in, pin<=0, attempts_left<=MAX_ATTEMPTS, digit count 0 -> GET_PIN.
- GET_PIN, valid digit (digit_valid with digit<=9): pin<=pin*10+digit (16-bit, no overflow for 4 digits), count++, timeout counter cleared.
- GET_PIN, invalid digit (digit>9): ignored, no count change.
- GET_PIN, last digit: on the cycle the PIN_DIGITS-th digit is accepted -> CHECK.
- GET_PIN, timeout: timeout counter increments on each cycle without a digit; reaching TIMEOUT_CYCLES-1 -> IDLE with status TIMEOUT and pin cleared.
- CHECK (exactly 1 cycle): Authenticator is combinational on the registered acc_num/pin, so results are sampled in this cycle. Priority order:
  - !auth_found -> IDLE, status NOT_FOUND.
  - auth_found and lock[auth_index] -> IDLE, status LOCKED, regardless of PIN.
  - auth_found and auth_ok -> GRANTED; session_index<=auth_index; session_active=1; status GRANTED.
  - auth_found and !auth_ok -> attempts_left--. If the new value is 0, set lock[auth_index] and go IDLE with status LOCKED; otherwise status BAD_PIN, pin<=0, count<=0 -> GET_PIN.
- auth_index>=NUM_ACCOUNTS is treated as NOT_FOUND.
- GRANTED: held until cancel; then -> IDLE, session_active drops the next cycle, status CANCELLED.
- Cancel in GET_PIN or CHECK: -> IDLE, pin cleared, status CANCELLED. In CHECK, cancel has priority over the auth result.
- card_in outside IDLE is ignored.
- Lock bits persist across sessions and are cleared only by rst.
- Latency: last digit -> status_valid is 2 cycles (CHECK, then result registered).
- rst mid-operation returns everything to the reset values on the next edge, including the lock bitmap.

Optional Feature:
- Macro: ADMIN_UNLOCK_EN.
- When defined: adds ports unlock_req (in, 1) and unlock_index (in, 4). A unlock_req pulse clears lock[unlock_index] on the next edge, in any state. If it coincides with a lock-set of the same index, unlock wins.
- When undefined: these ports are absent; locks clear only on rst.

Test Plan:
- card_in acc 1, digits 1,2,3,4, auth returns found/ok/index 0 -> status GRANTED, session_active=1, session_index=0, pin=1234 during CHECK.
- acc 3, PIN 3455 three times (auth found, !ok, index 2) -> BAD_PIN, BAD_PIN, LOCKED with attempts_left 2,1,0. New session entering 3456 -> LOCKED.
- acc 12, any 4 digits, auth_found=0 -> NOT_FOUND, return to IDLE, no lock change.
- acc 2, digits 2,3 then no input for TIMEOUT_CYCLES -> TIMEOUT, pin=0, state IDLE. Digit 0xB mid-entry -> ignored, count unchanged.
- cancel asserted in GET_PIN after 2 digits -> CANCELLED. cancel in GRANTED -> session_active low the next cycle.
- rst asserted during GET_PIN and after a lockout -> all outputs at reset values; the previously locked account authenticates normally afterwards. With ADMIN_UNLOCK_EN: unlock_index=2 clears the lock without rst.

Source files
------------

// File: rtl/atm_login_ctrl.sv
// ATM login session controller: card capture, PIN entry, auth result handling, retry limits and lockout.
// Optional macro ADMIN_UNLOCK_EN adds an unlock_req/unlock_index port pair for clearing individual locks.
module atm_login_ctrl #(
    parameter int MAX_ATTEMPTS   = 3,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int NUM_ACCOUNTS   = 10,
    parameter int PIN_DIGITS     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        card_in,
    input  logic [3:0]  acc_num_in,
    input  logic        digit_valid,
    input  logic [3:0]  digit,
    input  logic        cancel,
    input  logic        auth_found,
    input  logic        auth_ok,
    input  logic [3:0]  auth_index,
`ifdef ADMIN_UNLOCK_EN
    input  logic        unlock_req,
    input  logic [3:0]  unlock_index,
`endif
    output logic [3:0]  acc_num,
    output logic [15:0] pin,
    output logic        session_active,
    output logic [3:0]  session_index,
    output logic [1:0]  attempts_left,
    output logic [2:0]  status,
    output logic        status_valid
);

    localparam int CNT_W = $clog2(PIN_DIGITS + 1);
    localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [2:0] ST_NONE      = 3'd0;
    localparam logic [2:0] ST_GRANTED   = 3'd1;
    localparam logic [2:0] ST_BAD_PIN   = 3'd2;
    localparam logic [2:0] ST_NOT_FOUND = 3'd3;
    localparam logic [2:0] ST_LOCKED    = 3'd4;
    localparam logic [2:0] ST_TIMEOUT   = 3'd5;
    localparam logic [2:0] ST_CANCELLED = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE,
        S_GET_PIN,
        S_CHECK,
        S_GRANTED
    } state_t;

    state_t                  state_reg;
    logic [CNT_W-1:0]        count_reg;
    logic [TO_W-1:0]         timer_reg;
    logic [NUM_ACCOUNTS-1:0] locks;
    logic [15:0]             lock_vec;

    logic        digit_ok;
    logic        last_digit;
    logic        timer_expired;
    logic [15:0] pin_acc;
    logic        index_in_range;
    logic        acct_found;
    logic        acct_locked;
    logic        lock_set;

    assign digit_ok      = digit_valid && (digit <= 4'd9);
    assign last_digit    = (count_reg == CNT_W'(PIN_DIGITS - 1));
    assign timer_expired = (timer_reg == TO_W'(TIMEOUT_CYCLES - 1));

    // pin*10 + digit as shift-and-add; four decimal digits never exceed 16 bits
    assign pin_acc = {pin[12:0], 3'b000} + {pin[14:0], 1'b0} + {12'b0, digit};

    // Indices past the bitmap are reported as unknown accounts
    assign index_in_range = int'(auth_index) < NUM_ACCOUNTS;
    assign acct_found     = auth_found && index_in_range;
    assign lock_vec       = 16'(locks);
    assign acct_locked    = lock_vec[auth_index];

    assign lock_set = (state_reg == S_CHECK) && !cancel && acct_found && !acct_locked
                      && !auth_ok && (attempts_left == 2'd1);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_ACCOUNTS; gi++) begin : g_lock
            logic bit_reg;
            logic unlock_hit;
`ifdef ADMIN_UNLOCK_EN
            assign unlock_hit = unlock_req && (unlock_index == 4'(gi));
`else
            assign unlock_hit = 1'b0;
`endif
            // Unlock is checked first so it wins over a same-cycle lockout
            always_ff @(posedge clk) begin
                if (rst) begin
                    bit_reg <= 1'b0;
                end else if (unlock_hit) begin
                    bit_reg <= 1'b0;
                end else if (lock_set && (auth_index == 4'(gi))) begin
                    bit_reg <= 1'b1;
                end
            end
            assign locks[gi] = bit_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            count_reg      <= '0;
            timer_reg      <= '0;
            acc_num        <= 4'd0;
            pin            <= 16'd0;
            session_active <= 1'b0;
            session_index  <= 4'd0;
            attempts_left  <= 2'(MAX_ATTEMPTS);
            status         <= ST_NONE;
            status_valid   <= 1'b0;
        end else begin
            status_valid <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    timer_reg <= '0;
                    if (card_in) begin
                        acc_num       <= acc_num_in;
                        pin           <= 16'd0;
                        attempts_left <= 2'(MAX_ATTEMPTS);
                        count_reg     <= '0;
                        state_reg     <= S_GET_PIN;
                    end
                end

                S_GET_PIN: begin
                    if (cancel) begin
                        pin          <= 16'd0;
                        timer_reg    <= '0;
                        status       <= ST_CANCELLED;
                        status_valid <= 1'b1;
                        state_reg    <= S_IDLE;
                    end else if (digit_ok) begin
                        pin       <= pin_acc;
                        timer_reg <= '0;
                        if (last_digit) begin
                            count_reg <= '0;
                            state_reg <= S_CHECK;
                        end else begin
                            count_reg <= count_reg + CNT_W'(1);
                        end
                    end else if (timer_expired) begin
                        pin          <= 16'd0;
                        timer_reg    <= '0;
                        status       <= ST_TIMEOUT;
                        status_valid <= 1'b1;
                        state_reg    <= S_IDLE;
                    end else begin
                        timer_reg <= timer_reg + TO_W'(1);
                    end
                end

                // Authenticator is combinational on acc_num/pin, so its answer is valid here
                S_CHECK: begin
                    timer_reg    <= '0;
                    status_valid <= 1'b1;
                    if (cancel) begin
                        pin       <= 16'd0;
                        status    <= ST_CANCELLED;
                        state_reg <= S_IDLE;
                    end else if (!acct_found) begin
                        pin       <= 16'd0;
                        status    <= ST_NOT_FOUND;
                        state_reg <= S_IDLE;
                    end else if (acct_locked) begin
                        pin       <= 16'd0;
                        status    <= ST_LOCKED;
                        state_reg <= S_IDLE;
                    end else if (auth_ok) begin
                        session_index  <= auth_index;
                        session_active <= 1'b1;
                        status         <= ST_GRANTED;
                        state_reg      <= S_GRANTED;
                    end else begin
                        attempts_left <= attempts_left - 2'd1;
                        pin           <= 16'd0;
                        if (attempts_left == 2'd1) begin
                            status    <= ST_LOCKED;
                            state_reg <= S_IDLE;
                        end else begin
                            status    <= ST_BAD_PIN;
                            count_reg <= '0;
                            state_reg <= S_GET_PIN;
                        end
                    end
                end

                S_GRANTED: begin
                    if (cancel) begin
                        session_active <= 1'b0;
                        status         <= ST_CANCELLED;
                        status_valid   <= 1'b1;
                        state_reg      <= S_IDLE;
                    end
                end

                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_atm_login_ctrl.sv
// Testbench for atm_login_ctrl: directed scenarios followed by randomized sessions checked against
// an account/lockout model and a behavioural Authenticator built into the bench.
module tb_atm_login_ctrl;

    localparam int T_CYC = 20;
    localparam int N_ACC = 10;

    localparam int NONE = 0, GRANTED = 1, BAD_PIN = 2, NOT_FOUND = 3;
    localparam int LOCKED = 4, TIMEOUT = 5, CANCELLED = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        card_in = 1'b0;
    logic [3:0]  acc_num_in = 4'd0;
    logic        digit_valid = 1'b0;
    logic [3:0]  digit = 4'd0;
    logic        cancel = 1'b0;
    logic        auth_found;
    logic        auth_ok;
    logic [3:0]  auth_index;
`ifdef ADMIN_UNLOCK_EN
    logic        unlock_req = 1'b0;
    logic [3:0]  unlock_index = 4'd0;
`endif
    logic [3:0]  acc_num;
    logic [15:0] pin;
    logic        session_active;
    logic [3:0]  session_index;
    logic [1:0]  attempts_left;
    logic [2:0]  status;
    logic        status_valid;

    always #5 clk = ~clk;

    atm_login_ctrl #(
        .MAX_ATTEMPTS(3), .TIMEOUT_CYCLES(T_CYC), .NUM_ACCOUNTS(N_ACC), .PIN_DIGITS(4)
    ) dut (
        .clk(clk), .rst(rst), .card_in(card_in), .acc_num_in(acc_num_in),
        .digit_valid(digit_valid), .digit(digit), .cancel(cancel),
        .auth_found(auth_found), .auth_ok(auth_ok), .auth_index(auth_index),
`ifdef ADMIN_UNLOCK_EN
        .unlock_req(unlock_req), .unlock_index(unlock_index),
`endif
        .acc_num(acc_num), .pin(pin), .session_active(session_active),
        .session_index(session_index), .attempts_left(attempts_left),
        .status(status), .status_valid(status_valid)
    );

    // Account database: card number -> (authenticator index, PIN); acc 9 maps past the bitmap
    int db_acc[7] = '{1, 2, 3, 4, 5, 7, 9};
    int db_idx[7] = '{0, 1, 2, 3, 4, 9, 12};
    int db_pin[7] = '{1234, 5555, 3456, 7, 9999, 4321, 1111};

    function automatic int db_find(input int acc);
        for (int i = 0; i < 7; i++) if (db_acc[i] == acc) return i;
        return -1;
    endfunction

    // Behavioural Authenticator, combinational on the controller's registered outputs
    always_comb begin
        int k;
        k          = db_find(int'(acc_num));
        auth_found = (k >= 0);
        auth_ok    = (k >= 0) && (int'(pin) == db_pin[(k >= 0) ? k : 0]);
        auth_index = (k >= 0) ? 4'(db_idx[k]) : 4'd0;
    end

    int checks = 0;
    int failures = 0;
    bit locked[16];
    int attempts = 3;
    int exp_idx = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Session rules applied to one completed 4-digit entry
    function automatic int predict(input int acc, input int pv);
        int k;
        k = db_find(acc);
        if (k < 0 || db_idx[k] >= N_ACC) return NOT_FOUND;
        exp_idx = db_idx[k];
        if (locked[exp_idx]) return LOCKED;
        if (pv == db_pin[k]) return GRANTED;
        attempts = attempts - 1;
        if (attempts == 0) begin
            locked[exp_idx] = 1'b1;
            return LOCKED;
        end
        return BAD_PIN;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic key(input int d);
        digit_valid = 1'b1;
        digit = 4'(d);
        @(negedge clk);
        digit_valid = 1'b0;
    endtask

    task automatic card(input int acc);
        card_in = 1'b1;
        acc_num_in = 4'(acc);
        @(negedge clk);
        card_in = 1'b0;
        attempts = 3;
        check("card_acc_num", 32'(acc_num), 32'(acc & 15));
        check("card_attempts", 32'(attempts_left), 3);
    endtask

    task automatic do_cancel();
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
    endtask

    task automatic attempt(input int acc, input int pv, input bit noise, output int st);
        int dv[4];
        dv[0] = pv / 1000; dv[1] = (pv / 100) % 10; dv[2] = (pv / 10) % 10; dv[3] = pv % 10;
        for (int i = 0; i < 4; i++) begin
            if (noise && $urandom_range(0, 3) == 0) key(10 + int'($urandom_range(0, 5)));
            if (noise) repeat ($urandom_range(0, 2)) tick();
            key(dv[i]);
        end
        check("pin_in_check", 32'(pin), 32'(pv));
        check("no_early_valid", 32'(status_valid), 0);
        st = predict(acc, pv);
        tick();
        check("result_valid", 32'(status_valid), 1);
        check("result_status", 32'(status), 32'(st));
        check("result_attempts", 32'(attempts_left), 32'(attempts));
        if (st == GRANTED) begin
            check("granted_active", 32'(session_active), 1);
            check("granted_index", 32'(session_index), 32'(exp_idx));
        end
        $display("txn acc=%0d pin=%0d status=%0d attempts_left=%0d", acc, pv, status, attempts_left);
    endtask

    task automatic logout();
        repeat ($urandom_range(0, 3)) tick();
        do_cancel();
        check("logout_valid", 32'(status_valid), 1);
        check("logout_status", 32'(status), CANCELLED);
        check("logout_active", 32'(session_active), 0);
        $display("txn logout status=%0d session_active=%0d", status, session_active);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_acc_num"}, 32'(acc_num), 0);
        check({tag, "_pin"}, 32'(pin), 0);
        check({tag, "_active"}, 32'(session_active), 0);
        check({tag, "_index"}, 32'(session_index), 0);
        check({tag, "_attempts"}, 32'(attempts_left), 3);
        check({tag, "_status"}, 32'(status), NONE);
        check({tag, "_valid"}, 32'(status_valid), 0);
    endtask

    initial begin
        int st;
        int seen;
        int acc_pool[9] = '{1, 2, 3, 4, 5, 7, 9, 12, 0};

        rst = 1'b1;
        tick(); tick();
        check_reset_values("reset");
        rst = 1'b0;
        tick();

        // Successful login; a second card_in while entering digits must be ignored
        card(1);
        key(1);
        card_in = 1'b1; acc_num_in = 4'd5; tick(); card_in = 1'b0;
        check("card_ignored", 32'(acc_num), 1);
        key(2); key(3); key(4);
        check("pin_1234", 32'(pin), 1234);
        st = predict(1, 1234);
        tick();
        check("grant_valid", 32'(status_valid), 1);
        check("grant_status", 32'(status), GRANTED);
        check("grant_active", 32'(session_active), 1);
        check("grant_index", 32'(session_index), 0);
        $display("txn acc=1 pin=1234 status=%0d", status);
        tick();
        check("valid_one_cycle", 32'(status_valid), 0);
        check("status_held", 32'(status), GRANTED);
        logout();

        // Three wrong PINs lock the account; the correct PIN is then refused
        card(3);
        attempt(3, 3455, 1'b0, st); check("bad1", 32'(st), BAD_PIN); check("bad1_left", 32'(attempts_left), 2);
        attempt(3, 3455, 1'b0, st); check("bad2", 32'(st), BAD_PIN); check("bad2_left", 32'(attempts_left), 1);
        attempt(3, 3455, 1'b0, st); check("bad3", 32'(st), LOCKED); check("bad3_left", 32'(attempts_left), 0);
        card(3);
        attempt(3, 3456, 1'b0, st); check("locked_reentry", 32'(st), LOCKED);

        // Unknown account, and an account whose index is outside the bitmap
        card(12);
        attempt(12, 4321, 1'b0, st); check("unknown_acc", 32'(st), NOT_FOUND);
        card(9);
        attempt(9, 1111, 1'b0, st); check("index_range", 32'(st), NOT_FOUND);

        // Timeout with an invalid digit in the middle of entry
        card(2);
        key(2); key(11); key(3);
        check("invalid_ignored_pin", 32'(pin), 23);
        seen = 0;
        for (int k = 1; k < T_CYC; k++) begin
            tick();
            if (status_valid) seen = 1;
        end
        check("no_early_timeout", 32'(seen), 0);
        tick();
        check("timeout_valid", 32'(status_valid), 1);
        check("timeout_status", 32'(status), TIMEOUT);
        check("timeout_pin", 32'(pin), 0);
        $display("txn acc=2 timeout status=%0d", status);
        tick();
        check("timeout_pulse", 32'(status_valid), 0);

        // Cancel after two digits
        card(2);
        key(5); key(5);
        do_cancel();
        check("cancel_pin_valid", 32'(status_valid), 1);
        check("cancel_pin_status", 32'(status), CANCELLED);
        check("cancel_pin_cleared", 32'(pin), 0);
        $display("txn acc=2 cancel status=%0d", status);

        // Cancel in the check cycle beats a correct PIN
        card(1);
        key(1); key(2); key(3); key(4);
        do_cancel();
        check("cancel_check_status", 32'(status), CANCELLED);
        check("cancel_check_active", 32'(session_active), 0);
        $display("txn acc=1 cancel-in-check status=%0d", status);

        // Reset mid-entry clears everything, including the lock on account 3
        card(4);
        key(0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_values("midrst");
        for (int i = 0; i < 16; i++) locked[i] = 1'b0;
        card(3);
        attempt(3, 3456, 1'b0, st); check("unlocked_by_rst", 32'(st), GRANTED);
        logout();

`ifdef ADMIN_UNLOCK_EN
        card(3);
        for (int i = 0; i < 3; i++) attempt(3, 1000, 1'b0, st);
        check("relock", 32'(st), LOCKED);
        unlock_req = 1'b1; unlock_index = 4'd2;
        tick();
        unlock_req = 1'b0;
        locked[2] = 1'b0;
        card(3);
        attempt(3, 3456, 1'b0, st); check("admin_unlock", 32'(st), GRANTED);
        logout();
`endif

        // Randomized sessions against the model
        for (int s = 0; s < 40; s++) begin
            int acc, k, pv;
            acc = acc_pool[$urandom_range(0, 8)];
            k = db_find(acc);
            card(acc);
            if ($urandom_range(0, 7) == 0) begin
                key(int'($urandom_range(0, 9))); key(int'($urandom_range(0, 9)));
                do_cancel();
                check("rand_cancel", 32'(status), CANCELLED);
                $display("txn acc=%0d cancel status=%0d", acc, status);
                continue;
            end
            do begin
                pv = (k >= 0 && $urandom_range(0, 1) == 1) ? db_pin[k] : int'($urandom_range(0, 9999));
                attempt(acc, pv, 1'b1, st);
            end while (st == BAD_PIN);
            if (st == GRANTED) logout();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
